// File: rtl/uart_host_cmd_master.sv
// Host-side UART command initiator: frames START_BYTE + command byte, collects a 16-byte response.
// Optional response timeout is enabled by defining UART_HOST_RESP_TIMEOUT_EN.
module uart_host_cmd_master #(
    parameter logic [7:0] START_BYTE     = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter int         TO_W           = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    input  logic [7:0]   cmd_code,
    output logic         cmd_ready,
    output logic         tx_valid,
    output logic [7:0]   tx_byte,
    input  logic         tx_ready,
    input  logic         rx_valid,
    input  logic [7:0]   rx_byte,
    output logic [127:0] resp_data,
    output logic         resp_valid,
    output logic         bad_cmd,
    output logic         timeout_err,
    output logic         busy
);

    localparam logic [7:0] CMD_RESET = 8'h20;
    localparam logic [7:0] CMD_INFO  = 8'h15;

    typedef enum logic [2:0] {IDLE, SEND_START, SEND_CMD, RECV, DONE} state_t;

    state_t     state;
    logic [7:0] cmd_q;
    logic [3:0] cnt;

`ifdef UART_HOST_RESP_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cmd_q      <= '0;
            cnt        <= '0;
            resp_data  <= '0;
            tx_valid   <= 1'b0;
            tx_byte    <= '0;
            resp_valid <= 1'b0;
            bad_cmd    <= 1'b0;
`ifdef UART_HOST_RESP_TIMEOUT_EN
            to_cnt      <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            resp_valid <= 1'b0;
            bad_cmd    <= 1'b0;
`ifdef UART_HOST_RESP_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_code == CMD_RESET || cmd_code == CMD_INFO) begin
                            cmd_q    <= cmd_code;
                            tx_valid <= 1'b1;
                            tx_byte  <= START_BYTE;
                            state    <= SEND_START;
                        end else begin
                            bad_cmd <= 1'b1;
                        end
                    end
                end
                SEND_START: begin
                    if (tx_ready) begin
                        tx_byte <= cmd_q;
                        state   <= SEND_CMD;
                    end
                end
                SEND_CMD: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        tx_byte  <= '0;
                        if (cmd_q == CMD_INFO) begin
                            cnt       <= '0;
                            resp_data <= '0;
`ifdef UART_HOST_RESP_TIMEOUT_EN
                            to_cnt    <= '0;
`endif
                            state     <= RECV;
                        end else begin
                            resp_valid <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                RECV: begin
                    if (rx_valid) begin
                        resp_data <= {resp_data[119:0], rx_byte};
                        cnt       <= cnt + 4'd1;
`ifdef UART_HOST_RESP_TIMEOUT_EN
                        to_cnt    <= '0;
`endif
                        if (cnt == 4'd15) begin
                            resp_valid <= 1'b1;
                            state      <= DONE;
                        end
                    end
`ifdef UART_HOST_RESP_TIMEOUT_EN
                    // Silence on the line for the full window aborts the frame, keeping partial bytes.
                    else if (to_cnt == TO_LAST) begin
                        to_cnt      <= '0;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_host_cmd_master.sv
// Directed bench for uart_host_cmd_master; timeout section follows UART_HOST_RESP_TIMEOUT_EN.
module tb_uart_host_cmd_master;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic [7:0]   cmd_code;
    logic         cmd_ready;
    logic         tx_valid;
    logic [7:0]   tx_byte;
    logic         tx_ready;
    logic         rx_valid;
    logic [7:0]   rx_byte;
    logic [127:0] resp_data;
    logic         resp_valid;
    logic         bad_cmd;
    logic         timeout_err;
    logic         busy;

    int n_chk  = 0;
    int n_pass = 0;

    uart_host_cmd_master #(.START_BYTE(8'hA5), .TIMEOUT_CYCLES(50), .TO_W(20)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ready(cmd_ready),
        .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_byte(rx_byte),
        .resp_data(resp_data), .resp_valid(resp_valid), .bad_cmd(bad_cmd),
        .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Present a command for one cycle in IDLE; returns at the negedge after acceptance.
    task automatic issue(input logic [7:0] code);
        cmd_valid = 1'b1;
        cmd_code  = code;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic feed(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    logic ok;

    initial begin
        reset = 1'b0; cmd_valid = 1'b1; cmd_code = 8'h20;
        tx_ready = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pulses", {resp_valid, bad_cmd, timeout_err}, 3'b000);
        chk("rst_resp_data", resp_data, 128'h0);
        cmd_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1'b1);

        // RESET command, transmitter always ready
        issue(8'h20);
        chk("rc_start", {tx_valid, tx_byte, busy, cmd_ready}, {1'b1, 8'hA5, 1'b1, 1'b0});
        @(negedge clk);
        chk("rc_cmd", {tx_valid, tx_byte}, {1'b1, 8'h20});
        @(negedge clk);
        chk("rc_resp_valid", {resp_valid, tx_valid}, 2'b10);
        chk("rc_resp_data", resp_data, 128'h0);
        @(negedge clk);
        chk("rc_done", {resp_valid, busy, cmd_ready}, 3'b001);

        // GET_SD_INFO with a 5-cycle transmitter stall
        tx_ready = 1'b0;
        issue(8'h15);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!(tx_valid && tx_byte == 8'hA5)) ok = 1'b0;
            @(negedge clk);
        end
        chk("gi_stall_hold", ok, 1'b1);
        tx_ready = 1'b1;
        @(negedge clk);
        chk("gi_cmd", {tx_valid, tx_byte}, {1'b1, 8'h15});
        @(negedge clk);
        chk("gi_recv", {tx_valid, busy}, 2'b01);
        ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            feed(8'(i));
            if (i < 15 && resp_valid) ok = 1'b0;
        end
        chk("gi_no_early_valid", ok, 1'b1);
        chk("gi_resp_valid", resp_valid, 1'b1);
        chk("gi_resp_data", resp_data, 128'h000102030405060708090A0B0C0D0E0F);
        @(negedge clk);
        chk("gi_single_pulse", {resp_valid, busy}, 2'b00);

        // RESET must leave the previous response intact
        issue(8'h20);
        repeat (3) @(negedge clk);
        chk("rc_keeps_data", resp_data, 128'h000102030405060708090A0B0C0D0E0F);

        // Unsupported command
        issue(8'h99);
        chk("bad_pulse", {bad_cmd, tx_valid, cmd_ready}, 3'b101);
        @(negedge clk);
        chk("bad_once", {bad_cmd, tx_valid, cmd_ready, busy}, 4'b0010);

        // Stray byte in IDLE, then a frame with an ignored command during RECV
        feed(8'hFF);
        chk("stray_ignored", resp_data, 128'h000102030405060708090A0B0C0D0E0F);
        issue(8'h15);
        repeat (2) @(negedge clk);
        cmd_valid = 1'b1; cmd_code = 8'h20;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("busy_cmd_ignored", {tx_valid, cmd_ready}, 2'b00);
        for (int i = 0; i < 16; i++) feed(8'h10 + 8'(i));
        chk("st_resp", {resp_valid, resp_data}, {1'b1, 128'h101112131415161718191A1B1C1D1E1F});
        ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (tx_valid || busy) ok = 1'b0;
        end
        chk("no_queued_cmd", ok, 1'b1);

        // Response stalls after three bytes
        issue(8'h15);
        repeat (2) @(negedge clk);
        feed(8'hAA); feed(8'hBB); feed(8'hCC);
`ifdef UART_HOST_RESP_TIMEOUT_EN
        ok = 1'b1;
        for (int i = 0; i < 49; i++) begin
            @(negedge clk);
            if (timeout_err || !busy) ok = 1'b0;
        end
        chk("to_not_early", ok, 1'b1);
        @(negedge clk);
        chk("to_pulse", {timeout_err, resp_valid, busy}, 3'b100);
        chk("to_partial", resp_data, 128'hAABBCC);
        @(negedge clk);
        chk("to_once", {timeout_err, cmd_ready}, 2'b01);
`else
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy || resp_valid || timeout_err) ok = 1'b0;
        end
        chk("wait_forever", ok, 1'b1);
        chk("partial_data", resp_data, 128'hAABBCC);
        // Reset mid-frame abandons it without pulses
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("mid_reset", {busy, resp_valid, resp_data}, {2'b00, 128'h0});
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
